db4_lattice_dwt: RTL

Parametrised single-clock Daubechies-4 wavelet analysis stage in polyphase lattice form. It splits a sample stream into even/odd pairs, scales each pair by s≈124/256, applies the two lattice sections a0≈1.7321 and a1≈0.2679 with shift-add multipliers, and emits one lowpass (g) and one highpass (h) coefficient per input pair. It replaces the derived-clock lattice with a valid-qualified datapath on `clk`, so it can be cascaded for multi-level DWT trees.

---
 rtl/db4_lattice_dwt.sv | 106 ++++++++++
 1 files changed

// File: rtl/db4_lattice_dwt.sv
// db4_lattice_dwt: Daubechies-4 polyphase lattice analysis stage (one g/h pair per even/odd input pair).
// Latency: 2 clk from odd-sample acceptance to g/h/gh_valid; throughput one pair per two valid samples.
// Backpressure: none -- x_valid may be high every cycle; optional macro DB4_ROUND_EN selects round-half-up outputs.
module db4_lattice_dwt #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] x_in,
    input  logic                x_valid,
    output logic signed [W:0]   g,
    output logic signed [W:0]   h,
    output logic                gh_valid,
    output logic signed [W+10:0] x_e,
    output logic signed [W+10:0] x_o,
    output logic                phase
);

    localparam int IW = W + 11;

    // Even sample waiting for its odd partner.
    logic signed [W-1:0]  r_even;
    // One-cycle flag: x_e/x_o hold a freshly scaled pair.
    logic                 r_pend;
    // Lattice delay: so[n-1] - A0(se[n-1]).
    logic signed [IW-1:0] r_low;

    logic signed [IW-1:0] w_up0;
    logic signed [IW-1:0] w_low0;
    logic signed [IW-1:0] w_up1;
    logic signed [IW-1:0] w_low1;
    logic signed [IW-1:0] w_low_next;
    logic signed [IW-1:0] w_g_full;
    logic signed [IW-1:0] w_h_full;
    logic                 w_unused_bits;

    // Scale by 124 = 128 - 4 after sign-extending to the lattice width.
    function automatic logic signed [IW-1:0] f_scale(input logic signed [W-1:0] x);
        logic signed [IW-1:0] v;
        v = {{(IW-W){x[W-1]}}, x};
        return (v <<< 7) - (v <<< 2);
    endfunction

    // a0 ~ 1.7321 as shift-add.
    function automatic logic signed [IW-1:0] f_a0(input logic signed [IW-1:0] v);
        return (v <<< 1) - (v >>> 2) - (v >>> 6) - (v >>> 8);
    endfunction

    // a1 ~ 0.2679 as shift-add.
    function automatic logic signed [IW-1:0] f_a1(input logic signed [IW-1:0] v);
        return (v >>> 2) + (v >>> 6) + (v >>> 8);
    endfunction

    assign w_up0      = x_e + f_a0(x_o);
    assign w_low0     = r_low;
    assign w_up1      = w_up0 - f_a1(w_low0);
    assign w_low1     = w_low0 + f_a1(w_up0);
    assign w_low_next = x_o - f_a0(x_e);

`ifdef DB4_ROUND_EN
    // Round half up before dropping the 8 fraction bits.
    assign w_g_full = w_up1 + IW'(128);
    assign w_h_full = w_low1 + IW'(128);
`else
    // Plain floor: the slice below is an arithmetic shift by 8.
    assign w_g_full = w_up1;
    assign w_h_full = w_low1;
`endif

    // Fraction bits and the sign-extension headroom are not needed at the output.
    assign w_unused_bits = ^{w_g_full[IW-1:W+9], w_g_full[7:0],
                             w_h_full[IW-1:W+9], w_h_full[7:0]};

    // Input pairing, scaling, lattice update and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_even   <= '0;
            r_pend   <= 1'b0;
            r_low    <= '0;
            x_e      <= '0;
            x_o      <= '0;
            phase    <= 1'b0;
            g        <= '0;
            h        <= '0;
            gh_valid <= 1'b0;
        end else begin
            r_pend   <= x_valid & phase;
            gh_valid <= r_pend;
            if (x_valid) begin
                phase <= ~phase;
                if (!phase) begin
                    r_even <= x_in;
                end else begin
                    x_e <= f_scale(r_even);
                    x_o <= f_scale(x_in);
                end
            end
            if (r_pend) begin
                g     <= w_g_full[W+8:8];
                h     <= w_h_full[W+8:8];
                r_low <= w_low_next;
            end
        end
    end

endmodule
